// File: rtl/func_sweep_ctrl.sv
// func_sweep_ctrl: sweeps a 4-input function block through all vectors, captures truth tables and counts mismatches
module func_sweep_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp1,
  input  logic [15:0] exp2,
  input  logic        f1,
  input  logic        f2,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt1,
  output logic [15:0] tt2,
  output logic [5:0]  err_cnt,
  output logic        pass
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  localparam logic [3:0] SET = 4'(SETTLE);
  state_t state;
  logic [3:0] vec, cnt;
  logic [15:0] exp1_l, exp2_l;
  logic [5:0] err_nxt;
  assign {a, b, c, d} = vec;
  assign err_nxt = err_cnt + 6'(f1 != exp1_l[vec]) + 6'(f2 != exp2_l[vec]);
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state   <= S_IDLE;
      vec     <= '0;
      cnt     <= '0;
      exp1_l  <= '0;
      exp2_l  <= '0;
      tt1     <= '0;
      tt2     <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort) begin
      done <= 1'b0;
      if (state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        pass  <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: if (start) begin
          vec     <= '0;
          cnt     <= SET;
          exp1_l  <= exp1;
          exp2_l  <= exp2;
          tt1     <= '0;
          tt2     <= '0;
          err_cnt <= '0;
          pass    <= 1'b0;
          busy    <= 1'b1;
          state   <= S_SETTLE;
        end
        S_SETTLE: if (cnt == '0) state <= S_SAMPLE; else cnt <= cnt - 4'd1;
        S_SAMPLE: begin
          tt1[vec] <= f1;
          tt2[vec] <= f2;
          err_cnt  <= err_nxt;
          // pass is resolved from the final count here so it is already valid while done is high
          if (vec == 4'd15) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
            state <= S_DONE;
          end else begin
            vec   <= vec + 4'd1;
            cnt   <= SET;
            state <= S_SETTLE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_func_sweep_ctrl.sv
// tb_func_sweep_ctrl: directed and randomized sweeps of two controllers (SETTLE=1 and SETTLE=0) against a truth-table model
module tb_func_sweep_ctrl;
  logic clk = 1'b0, reset_b = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] exp1 = '0, exp2 = '0, ft1 = 16'hFF5E, ft2 = 16'h5505;
  logic a1, b1, c1, d1, busy1, done1, pass1;
  logic a0, b0, c0, d0, busy0, done0, pass0;
  logic [15:0] tt1_1, tt2_1, tt1_0, tt2_0;
  logic [5:0] err1, err0;
  logic [3:0] v1, v0;
  int checks = 0, failures = 0;
  int dc1, dc0, vb, np;
  assign v1 = {a1, b1, c1, d1};
  assign v0 = {a0, b0, c0, d0};
  always #5 clk = ~clk;
  func_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort), .exp1(exp1), .exp2(exp2),
    .f1(ft1[v1]), .f2(ft2[v1]), .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .tt1(tt1_1), .tt2(tt2_1), .err_cnt(err1), .pass(pass1));
  func_sweep_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort), .exp1(exp1), .exp2(exp2),
    .f1(ft1[v0]), .f2(ft2[v0]), .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
    .tt1(tt1_0), .tt2(tt2_0), .err_cnt(err0), .pass(pass0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic int model_err(input logic [15:0] m1, input logic [15:0] m2);
    return $countones((ft1 ^ exp1) & m1) + $countones((ft2 ^ exp2) & m2);
  endfunction
  // one sweep from IDLE; watches 60 cycles, cycle 1 being the one right after the accepting edge
  task automatic sweep(input bit spam, output int d1, output int d0, output int vbad, output int npulse);
    int cyc;
    start = 1'b1;
    @(negedge clk);
    start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
    d1 = 0; d0 = 0; vbad = 0; npulse = 0;
    for (cyc = 1; cyc < 60; cyc++) begin
      if (cyc <= 48 && v1 != 4'((cyc - 1) / 3)) vbad++;
      if (done1) begin npulse++; if (d1 == 0) d1 = cyc; end
      if (done0 && d0 == 0) d0 = cyc;
      @(negedge clk);
      start = (spam && cyc < 28) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
  endtask
  task automatic check_run(input string tag, input int d1, input int d0, input int vbad, input int npulse);
    int e = model_err(16'hFFFF, 16'hFFFF);
    chk({tag, "_done_cyc"}, 32'(d1), 32'd49);
    chk({tag, "_done_cyc_s0"}, 32'(d0), 32'd33);
    chk({tag, "_vec_seq"}, 32'(vbad), 32'd0);
    chk({tag, "_done_pulses"}, 32'(npulse), 32'd1);
    chk({tag, "_tt1"}, 32'(tt1_1), 32'(ft1));
    chk({tag, "_tt2"}, 32'(tt2_1), 32'(ft2));
    chk({tag, "_err"}, 32'(err1), 32'(e));
    chk({tag, "_pass"}, 32'(pass1), 32'(e == 0));
    chk({tag, "_tt1_s0"}, 32'(tt1_0), 32'(ft1));
    chk({tag, "_err_s0"}, 32'(err0), 32'(e));
    chk({tag, "_busy_idle"}, 32'(busy1), 32'd0);
  endtask
  initial begin
    #1;
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_vec", 32'(v1), 0);
    chk("rst_tt", 32'({tt1_1, tt2_1}), 0);
    chk("rst_err_pass", 32'({err1, pass1}), 0);
    @(negedge clk); @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    exp1 = 16'hFF5E; exp2 = 16'h5505;
    sweep(1'b0, dc1, dc0, vb, np);
    check_run("match", dc1, dc0, vb, np);
    exp1 = 16'hFF5F; exp2 = 16'h5504;
    sweep(1'b0, dc1, dc0, vb, np);
    check_run("err2", dc1, dc0, vb, np);
    chk("err2_abs", 32'(err1), 32'd2);
    exp1 = ~16'hFF5E; exp2 = ~16'h5505;
    sweep(1'b0, dc1, dc0, vb, np);
    check_run("err32", dc1, dc0, vb, np);
    chk("err32_abs", 32'(err1), 32'd32);
    // abort once vec reaches 7: bits 0..6 captured, bit 7 still in settle
    exp1 = 16'hFF5E; exp2 = 16'h5505;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && v1 != 4'd7; i++) @(negedge clk);
    chk("abort_reach_vec7", 32'(v1), 32'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_tt1", 32'(tt1_1), 32'(ft1 & 16'h007F));
    chk("abort_tt1_lo", 32'(tt1_1[7:0]), 32'h5E);
    chk("abort_err", 32'(err1), 32'(model_err(16'h007F, 16'h007F)));
    chk("abort_pass", 32'(pass1), 0);
    np = 0;
    for (int i = 0; i < 60; i++) begin
      if (done1 || done0) np++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(np), 0);
    sweep(1'b0, dc1, dc0, vb, np);
    check_run("after_abort", dc1, dc0, vb, np);
    sweep(1'b1, dc1, dc0, vb, np);
    check_run("spam", dc1, dc0, vb, np);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'({busy1, busy0}), 0);
    @(negedge clk);
    chk("start_abort_busy2", 32'({busy1, busy0}), 0);
    // asynchronous reset between edges
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("pre_rst_tt1", 32'(tt1_1 != 0), 1);
    #2 reset_b = 1'b0;
    #1;
    chk("arst_busy", 32'({busy1, busy0}), 0);
    chk("arst_vec", 32'(v1), 0);
    chk("arst_tt", 32'({tt1_1, tt2_1}), 0);
    chk("arst_err", 32'(err1), 0);
    np = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done1 || done0 || busy1) np++;
    end
    reset_b = 1'b1;
    chk("arst_quiet", 32'(np), 0);
    @(negedge clk);
    sweep(1'b0, dc1, dc0, vb, np);
    check_run("post_rst", dc1, dc0, vb, np);
    for (int r = 0; r < 6; r++) begin
      ft1 = 16'($urandom);
      ft2 = 16'($urandom);
      exp1 = (r % 3 == 0) ? ft1 : ft1 ^ (16'($urandom) & 16'($urandom));
      exp2 = (r % 3 == 0) ? ft2 : ft2 ^ (16'($urandom) & 16'($urandom));
      sweep(1'b0, dc1, dc0, vb, np);
      check_run($sformatf("rand%0d", r), dc1, dc0, vb, np);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
